// File: rtl/cpu_pkg.sv
// Shared definitions for the streamline CPU pipeline: datapath defaults,
// write-back source encoding and the LUI placement helper.
package cpu_pkg;

    localparam int XLEN_DEFAULT   = 32;
    localparam int REG_AW_DEFAULT = 5;

    // LUI places the 16-bit immediate in the top half of a default-width word.
    localparam int LUI_SHIFT = XLEN_DEFAULT - 16;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_RAM  = 2'd1,
        WB_LINK = 2'd2,
        WB_LUI  = 2'd3
    } wb_sel_e;

    // Shift that lands a 16-bit immediate in the top bits of an xlen-wide word.
    function automatic int lui_shift(input int xlen);
        return xlen - 16;
    endfunction

endpackage

// File: rtl/wb_mux.sv
// Write-back source select: picks link address, LUI immediate, load data or
// ALU result with priority jal > lui > memtoreg > alu.
module wb_mux
    import cpu_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int LINK_OFS = 1
) (
    input  logic            jal_i,
    input  logic            lui_i,
    input  logic            memtoreg_i,
    input  logic [15:0]     imm16_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] alu_i,
    input  logic [XLEN-1:0] ram_i,
    output wb_sel_e         sel_o,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0] link_val;
    logic [XLEN-1:0] lui_val;

    // Link wraps modulo 2^XLEN; the immediate fills the top 16 bits.
    always_comb begin
        link_val = pc_i + XLEN'(LINK_OFS);
        lui_val  = XLEN'(imm16_i) << lui_shift(XLEN);
    end

    // Priority decode of the control bits into a source select.
    always_comb begin
        sel_o = WB_ALU;
        if (jal_i) begin
            sel_o = WB_LINK;
        end else if (lui_i) begin
            sel_o = WB_LUI;
        end else if (memtoreg_i) begin
            sel_o = WB_RAM;
        end
    end

    // Route the selected operand to the write data.
    always_comb begin
        data_o = alu_i;
        case (sel_o)
            WB_LINK: data_o = link_val;
            WB_LUI:  data_o = lui_val;
            WB_RAM:  data_o = ram_i;
            default: data_o = alu_i;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back select, valid/stall/flush control
// and a retired-instruction counter. Outputs come straight from registers;
// the register-file write port doubles as the forwarding source.
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int REG_AW   = REG_AW_DEFAULT,
    parameter int LINK_OFS = 1,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              cnt_clr_i,
    input  logic              valid_i,
    input  logic [REG_AW-1:0] rw_i,
    input  logic              regwrite_i,
    input  logic              memtoreg_i,
    input  logic              jal_i,
    input  logic              lui_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   alu_i,
    input  logic [XLEN-1:0]   ram_i,
    output logic              valid_o,
    output logic              we_o,
    output logic [REG_AW-1:0] rw_o,
    output logic [XLEN-1:0]   wd_o,
    output logic [XLEN-1:0]   pc_o,
    output logic [CNT_W-1:0]  retire_cnt_o
);

    wb_sel_e           wb_sel;
    logic [XLEN-1:0]   wb_data;

    logic              valid_q;
    logic              wen_q;
    logic [REG_AW-1:0] rw_q;
    logic [XLEN-1:0]   wd_q;
    logic [XLEN-1:0]   pc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              capture;

    wb_mux #(
        .XLEN     (XLEN),
        .LINK_OFS (LINK_OFS)
    ) u_wb_mux (
        .jal_i      (jal_i),
        .lui_i      (lui_i),
        .memtoreg_i (memtoreg_i),
        .imm16_i    (imm_i[15:0]),
        .pc_i       (pc_i),
        .alu_i      (alu_i),
        .ram_i      (ram_i),
        .sel_o      (wb_sel),
        .data_o     (wb_data)
    );

    // Upper immediate bits are not part of the LUI encoding.
    if (XLEN > 16) begin : g_imm_hi
        logic unused_imm_hi;
        assign unused_imm_hi = ^imm_i[XLEN-1:16];
    end

    // A real instruction retires into WB only on an unstalled, unflushed edge.
    assign capture = valid_i & ~flush_i & ~stall_i;

    // Stage registers: flush loads a bubble and beats stall; stall holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            wen_q   <= 1'b0;
            rw_q    <= '0;
            wd_q    <= '0;
            pc_q    <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            wen_q   <= 1'b0;
            rw_q    <= '0;
            wd_q    <= '0;
            pc_q    <= '0;
        end else if (!stall_i) begin
            valid_q <= valid_i;
            wen_q   <= regwrite_i;
            rw_q    <= rw_i;
            wd_q    <= wb_data;
            pc_q    <= pc_i;
        end
    end

    // Retire counter: clear beats increment, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (cnt_clr_i) begin
            cnt_q <= '0;
        end else if (capture) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Jumps must always take the link path regardless of other controls.
    a_link_sel: assert property (@(posedge clk) disable iff (!rst)
        jal_i |-> (wb_sel == WB_LINK));

    // Writes to register 0 are dropped here so consumers never see them.
    assign we_o         = valid_q & wen_q & (rw_q != '0);
    assign valid_o      = valid_q;
    assign rw_o         = rw_q;
    assign wd_o         = wd_q;
    assign pc_o         = pc_q;
    assign retire_cnt_o = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// behavioural model. A second instance with a 4-bit counter checks wrap.
module tb_mem_wb_stage;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              stall_i, flush_i, cnt_clr_i, valid_i;
    logic [REG_AW-1:0] rw_i;
    logic              regwrite_i, memtoreg_i, jal_i, lui_i;
    logic [XLEN-1:0]   imm_i, pc_i, alu_i, ram_i;

    logic              valid_o, we_o;
    logic [REG_AW-1:0] rw_o;
    logic [XLEN-1:0]   wd_o, pc_o;
    logic [31:0]       retire_cnt_o;

    logic              valid4_o, we4_o;
    logic [REG_AW-1:0] rw4_o;
    logic [XLEN-1:0]   wd4_o, pc4_o;
    logic [3:0]        retire_cnt4_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .cnt_clr_i(cnt_clr_i), .valid_i(valid_i), .rw_i(rw_i),
        .regwrite_i(regwrite_i), .memtoreg_i(memtoreg_i), .jal_i(jal_i),
        .lui_i(lui_i), .imm_i(imm_i), .pc_i(pc_i), .alu_i(alu_i), .ram_i(ram_i),
        .valid_o(valid_o), .we_o(we_o), .rw_o(rw_o), .wd_o(wd_o), .pc_o(pc_o),
        .retire_cnt_o(retire_cnt_o)
    );

    mem_wb_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .cnt_clr_i(cnt_clr_i), .valid_i(valid_i), .rw_i(rw_i),
        .regwrite_i(regwrite_i), .memtoreg_i(memtoreg_i), .jal_i(jal_i),
        .lui_i(lui_i), .imm_i(imm_i), .pc_i(pc_i), .alu_i(alu_i), .ram_i(ram_i),
        .valid_o(valid4_o), .we_o(we4_o), .rw_o(rw4_o), .wd_o(wd4_o), .pc_o(pc4_o),
        .retire_cnt_o(retire_cnt4_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic              m_valid = 1'b0;
    logic              m_wen   = 1'b0;
    logic [REG_AW-1:0] m_rw    = '0;
    logic [XLEN-1:0]   m_wd    = '0;
    logic [XLEN-1:0]   m_pc    = '0;
    logic [31:0]       m_cnt   = '0;
    logic [3:0]        m_cnt4  = '0;

    function automatic logic [XLEN-1:0] ref_wd();
        if (jal_i)      return pc_i + 32'd1;
        if (lui_i)      return {imm_i[15:0], 16'h0000};
        if (memtoreg_i) return ram_i;
        return alu_i;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0; m_wen <= 1'b0; m_rw <= '0; m_wd <= '0; m_pc <= '0;
            m_cnt <= '0; m_cnt4 <= '0;
        end else begin
            if (cnt_clr_i) begin
                m_cnt <= '0; m_cnt4 <= '0;
            end else if (valid_i && !flush_i && !stall_i) begin
                m_cnt <= m_cnt + 32'd1; m_cnt4 <= m_cnt4 + 4'd1;
            end
            if (flush_i) begin
                m_valid <= 1'b0; m_wen <= 1'b0; m_rw <= '0; m_wd <= '0; m_pc <= '0;
            end else if (!stall_i) begin
                m_valid <= valid_i; m_wen <= regwrite_i; m_rw <= rw_i;
                m_wd <= ref_wd(); m_pc <= pc_i;
            end
        end
    end

    // Per-cycle compare on the falling edge, away from captures.
    always @(negedge clk) begin
        logic exp_we;
        exp_we = m_valid && m_wen && (m_rw != 0);
        chk("valid_o", valid_o, m_valid);
        chk("we_o", we_o, exp_we);
        chk("rw_o", rw_o, m_rw);
        chk("wd_o", wd_o, m_wd);
        chk("pc_o", pc_o, m_pc);
        chk("retire_cnt_o", retire_cnt_o, m_cnt);
        chk("w4 we_o", we4_o, exp_we);
        chk("w4 wd_o", wd4_o, m_wd);
        chk("w4 retire_cnt_o", retire_cnt4_o, m_cnt4);
    end

    // ---------------- stimulus ----------------
    task automatic clear_in();
        stall_i = 0; flush_i = 0; cnt_clr_i = 0; valid_i = 0; rw_i = '0;
        regwrite_i = 0; memtoreg_i = 0; jal_i = 0; lui_i = 0;
        imm_i = '0; pc_i = '0; alu_i = '0; ram_i = '0;
    endtask

    task automatic rand_in();
        valid_i = $urandom_range(0, 1); rw_i = REG_AW'($urandom);
        regwrite_i = $urandom_range(0, 1); memtoreg_i = $urandom_range(0, 1);
        jal_i = ($urandom_range(0, 3) == 0); lui_i = ($urandom_range(0, 3) == 0);
        imm_i = $urandom; pc_i = $urandom; alu_i = $urandom; ram_i = $urandom;
    endtask

    task automatic capture(input logic [REG_AW-1:0] rw, input logic [XLEN-1:0] alu);
        clear_in(); valid_i = 1; regwrite_i = 1; rw_i = rw; alu_i = alu;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        clear_in();
        rst = 0;
        // Reset held with inputs toggling.
        repeat (3) begin
            rand_in(); stall_i = $urandom_range(0, 1); flush_i = $urandom_range(0, 1);
            tick();
            chk("reset valid_o", valid_o, 0);
            chk("reset wd_o", wd_o, 0);
            chk("reset cnt", retire_cnt_o, 0);
        end
        #1;
        capture(5'd3, 32'h1234);
        rst = 1;
        tick();
        chk("first wd_o", wd_o, 32'h1234);
        chk("first we_o", we_o, 1);
        chk("first cnt", retire_cnt_o, 1);

        // Select priority.
        capture(5'd1, 32'h66); jal_i = 1; lui_i = 1; memtoreg_i = 1;
        pc_i = 32'h40; imm_i = 32'h0000ABCD; ram_i = 32'h55;
        tick();
        chk("jal wd_o", wd_o, 32'h41);
        chk("jal pc_o", pc_o, 32'h40);
        capture(5'd1, 32'h66); lui_i = 1; memtoreg_i = 1; imm_i = 32'h1234ABCD; ram_i = 32'h55;
        tick();
        chk("lui wd_o", wd_o, 32'hABCD0000);
        capture(5'd1, 32'h66); memtoreg_i = 1; ram_i = 32'hDEADBEEF;
        tick();
        chk("ram wd_o", wd_o, 32'hDEADBEEF);

        // Register 0 and invalid slot suppress writes.
        capture(5'd0, 32'h99);
        tick();
        chk("r0 we_o", we_o, 0);
        chk("r0 valid_o", valid_o, 1);
        capture(5'd4, 32'h99); valid_i = 0;
        tick();
        chk("invalid we_o", we_o, 0);
        chk("invalid valid_o", valid_o, 0);

        // Stall holds everything.
        capture(5'd5, 32'h7);
        tick();
        chk("pre-stall cnt", retire_cnt_o, 6);
        repeat (3) begin
            capture(5'd9, 32'h99); stall_i = 1;
            tick();
            chk("stall rw_o", rw_o, 5);
            chk("stall wd_o", wd_o, 7);
            chk("stall cnt", retire_cnt_o, 6);
        end
        capture(5'd9, 32'h99); stall_i = 1; flush_i = 1;
        tick();
        chk("flush valid_o", valid_o, 0);
        chk("flush we_o", we_o, 0);
        chk("flush cnt", retire_cnt_o, 6);

        // Counter clear and wrap.
        capture(5'd2, 32'h1); cnt_clr_i = 1;
        tick();
        chk("clr cnt", retire_cnt_o, 0);
        chk("clr cnt4", retire_cnt4_o, 0);
        for (int i = 0; i < 10; i++) begin
            capture(5'd2, 32'(i)); tick();
        end
        chk("ten cnt", retire_cnt_o, 10);
        for (int i = 0; i < 7; i++) begin
            capture(5'd2, 32'(i)); tick();
        end
        chk("seventeen cnt", retire_cnt_o, 17);
        chk("wrap cnt4", retire_cnt4_o, 1);

        // Asynchronous reset between edges.
        capture(5'd2, 32'h77);
        tick();
        #2 rst = 0;
        #1;
        chk("async valid_o", valid_o, 0);
        chk("async wd_o", wd_o, 0);
        chk("async cnt", retire_cnt_o, 0);
        rst = 1;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            rand_in();
            stall_i   = ($urandom_range(0, 5) == 0);
            flush_i   = ($urandom_range(0, 7) == 0);
            cnt_clr_i = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 39) == 0) begin
                rst = 0; #1;
                chk("rand async cnt", retire_cnt_o, 0);
                rst = 1;
            end
        end
        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
